// File: rtl/tlb_entry_pkg.sv
// Shared types and constants for the TLB entry-data store.
// Flag vector layout (bit 13 first):
//   {u,g,ae,sw,sx,sr,pw,px,pr,pal,paa,eff,c,fragmented_superpage}
package tlb_entry_pkg;

  localparam int unsigned FLAG_W    = 14;
  localparam int unsigned DEF_PPN_W = 20;

  // Bit positions inside the flag vector
  localparam int unsigned U              = 13;
  localparam int unsigned G              = 12;
  localparam int unsigned AE             = 11;
  localparam int unsigned SW             = 10;
  localparam int unsigned SX             = 9;
  localparam int unsigned SR             = 8;
  localparam int unsigned PW             = 7;
  localparam int unsigned PX             = 6;
  localparam int unsigned PR             = 5;
  localparam int unsigned PAL            = 4;
  localparam int unsigned PAA            = 3;
  localparam int unsigned EFF            = 2;
  localparam int unsigned C              = 1;
  localparam int unsigned FRAG_SUPERPAGE = 0;

  // Entry payload at the default ppn width
  typedef struct packed {
    logic [DEF_PPN_W-1:0] ppn;
    logic [FLAG_W-1:0]    flags;
  } entry_data_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

endpackage

// File: rtl/tlb_entry_flush_fsm.sv
// Flush sequencer: walks every entry once, one per cycle, after a flush request.
// Ports:
//   clock, reset     : clock, synchronous active-high reset
//   flush_valid      : flush request (ignored while busy)
//   flush_keep_g     : captured with the request; keep global entries
//   busy             : flush walk in progress
//   keep_g           : captured keep-global setting for the current walk
//   clr_en_c         : combinational clear-enable for entry clr_idx this cycle
//   clr_idx          : entry being visited by the walk
module tlb_entry_flush_fsm
  import tlb_entry_pkg::*;
#(
  parameter int unsigned ENTRIES = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush_valid,
  input  logic                       flush_keep_g,
  output logic                       busy,
  output logic                       keep_g,
  output logic                       clr_en_c,
  output logic [$clog2(ENTRIES)-1:0] clr_idx
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  flush_state_t     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             keep_g_q, keep_g_d;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      keep_g_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      keep_g_q <= keep_g_d;
    end
  end

  // Next-state and clear-enable
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    keep_g_d = keep_g_q;
    clr_en_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_valid) begin
          state_d  = FLUSH;
          ptr_d    = '0;
          keep_g_d = flush_keep_g;
        end
      end
      FLUSH: begin
        clr_en_c = 1'b1;
        ptr_d    = ptr_q + IDX_W'(1);
        if (ptr_q == IDX_W'(ENTRIES - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == FLUSH);
  assign keep_g  = keep_g_q;
  assign clr_idx = ptr_q;

endmodule

// File: rtl/tlb_entry_data_store.sv
// TLB entry-data store: holds ppn + flags per entry, accepts refill writes,
// serves a 1-cycle registered read port and runs sfence-style flushes.
// Optional build macro: TLB_ENTRY_PARITY_EN adds one even-parity bit per entry
// and drives io_r_perr; otherwise io_r_perr is always 0.
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   io_w_*                       : refill write (valid/ready, idx, ppn, flags)
//   io_r_valid, io_r_idx         : read request
//   io_r_resp_valid/hit/ppn/flags/perr : registered read response
//   io_flush_valid/keep_g/busy   : flush control and status
module tlb_entry_data_store
  import tlb_entry_pkg::*;
#(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned PPN_W   = 20
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_w_valid,
  output logic                       io_w_ready,
  input  logic [$clog2(ENTRIES)-1:0] io_w_idx,
  input  logic [PPN_W-1:0]           io_w_ppn,
  input  logic [FLAG_W-1:0]          io_w_flags,
  input  logic                       io_r_valid,
  input  logic [$clog2(ENTRIES)-1:0] io_r_idx,
  output logic                       io_r_resp_valid,
  output logic                       io_r_hit,
  output logic [PPN_W-1:0]           io_r_ppn,
  output logic [FLAG_W-1:0]          io_r_flags,
  output logic                       io_r_perr,
  input  logic                       io_flush_valid,
  input  logic                       io_flush_keep_g,
  output logic                       io_flush_busy
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic [PPN_W-1:0]  ppn;
    logic [FLAG_W-1:0] flags;
  } entry_t;

  entry_t             data_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;

  logic               busy;
  logic               keep_g;
  logic               clr_en_c;
  logic [IDX_W-1:0]   clr_idx;

  logic               w_fire_c;
  logic               byp_c;
  logic               rd_hit_c;
  entry_t             rd_data_c;
  logic               perr_c;

  tlb_entry_flush_fsm #(
    .ENTRIES (ENTRIES)
  ) u_flush_fsm (
    .clock        (clock),
    .reset        (reset),
    .flush_valid  (io_flush_valid),
    .flush_keep_g (io_flush_keep_g),
    .busy         (busy),
    .keep_g       (keep_g),
    .clr_en_c     (clr_en_c),
    .clr_idx      (clr_idx)
  );

  // A flush request in the same cycle takes priority over a refill
  assign io_w_ready    = !reset && !busy && !io_flush_valid;
  assign w_fire_c      = io_w_valid && io_w_ready;
  assign io_flush_busy = busy;

  // Payload storage; contents of invalid entries are never exposed
  always_ff @(posedge clock) begin
    if (w_fire_c) begin
      data_q[io_w_idx] <= '{ppn: io_w_ppn, flags: io_w_flags};
    end
  end

  // Valid bits: flush walk clears, refill sets (never both in one cycle)
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (clr_en_c && !(keep_g && data_q[clr_idx].flags[G])) begin
        valid_q[clr_idx] <= 1'b0;
      end
      if (w_fire_c) begin
        valid_q[io_w_idx] <= 1'b1;
      end
    end
  end

  // Write-first bypass for a same-index refill
  always_comb begin
    byp_c     = w_fire_c && (io_w_idx == io_r_idx);
    rd_hit_c  = byp_c || valid_q[io_r_idx];
    rd_data_c = byp_c ? entry_t'({io_w_ppn, io_w_flags}) : data_q[io_r_idx];
  end

`ifdef TLB_ENTRY_PARITY_EN
  logic [ENTRIES-1:0] par_q;

  // Even parity over {ppn,flags} captured on refill
  always_ff @(posedge clock) begin
    if (w_fire_c) begin
      par_q[io_w_idx] <= ^{io_w_ppn, io_w_flags};
    end
  end

  assign perr_c = rd_hit_c && !byp_c && ((^rd_data_c) != par_q[io_r_idx]);
`else
  assign perr_c = 1'b0;
`endif

  // Read response register; data holds until the next read, perr pulses with resp_valid
  always_ff @(posedge clock) begin
    if (reset) begin
      io_r_resp_valid <= 1'b0;
      io_r_hit        <= 1'b0;
      io_r_ppn        <= '0;
      io_r_flags      <= '0;
      io_r_perr       <= 1'b0;
    end else begin
      io_r_resp_valid <= io_r_valid;
      io_r_perr       <= 1'b0;
      if (io_r_valid) begin
        io_r_hit   <= rd_hit_c;
        io_r_ppn   <= rd_hit_c ? rd_data_c.ppn : '0;
        io_r_flags <= rd_hit_c ? rd_data_c.flags : '0;
        io_r_perr  <= perr_c;
      end
    end
  end

endmodule

// File: tb/tb_tlb_entry_data_store.sv
// Self-checking bench for tlb_entry_data_store: table-driven read/write vectors
// with a response scoreboard, plus hand-written flush and reset sequences.
module tb_tlb_entry_data_store;

  localparam int unsigned ENTRIES = 8;
  localparam int unsigned PPN_W   = 20;
  localparam int unsigned FLAG_W  = 14;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned GBIT    = 12;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_w_valid;
  logic              io_w_ready;
  logic [IDX_W-1:0]  io_w_idx;
  logic [PPN_W-1:0]  io_w_ppn;
  logic [FLAG_W-1:0] io_w_flags;
  logic              io_r_valid;
  logic [IDX_W-1:0]  io_r_idx;
  logic              io_r_resp_valid;
  logic              io_r_hit;
  logic [PPN_W-1:0]  io_r_ppn;
  logic [FLAG_W-1:0] io_r_flags;
  logic              io_r_perr;
  logic              io_flush_valid;
  logic              io_flush_keep_g;
  logic              io_flush_busy;

  always #5 clock = ~clock;

  tlb_entry_data_store #(
    .ENTRIES (ENTRIES),
    .PPN_W   (PPN_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .io_w_valid      (io_w_valid),
    .io_w_ready      (io_w_ready),
    .io_w_idx        (io_w_idx),
    .io_w_ppn        (io_w_ppn),
    .io_w_flags      (io_w_flags),
    .io_r_valid      (io_r_valid),
    .io_r_idx        (io_r_idx),
    .io_r_resp_valid (io_r_resp_valid),
    .io_r_hit        (io_r_hit),
    .io_r_ppn        (io_r_ppn),
    .io_r_flags      (io_r_flags),
    .io_r_perr       (io_r_perr),
    .io_flush_valid  (io_flush_valid),
    .io_flush_keep_g (io_flush_keep_g),
    .io_flush_busy   (io_flush_busy)
  );

  typedef struct packed {
    logic              hit;
    logic [PPN_W-1:0]  ppn;
    logic [FLAG_W-1:0] flags;
    logic              perr;
  } resp_t;

  typedef struct packed {
    logic              w_valid;
    logic [IDX_W-1:0]  w_idx;
    logic [PPN_W-1:0]  w_ppn;
    logic [FLAG_W-1:0] w_flags;
    logic              r_valid;
    logic [IDX_W-1:0]  r_idx;
    logic              exp_hit;
    logic [PPN_W-1:0]  exp_ppn;
    logic [FLAG_W-1:0] exp_flags;
  } vec_t;

  resp_t exp_q[$];
  vec_t  vecs[9];
  int    checks = 0;
  int    passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic wv, input logic [IDX_W-1:0] wi, input logic [PPN_W-1:0] wp,
                       input logic [FLAG_W-1:0] wf, input logic rv, input logic [IDX_W-1:0] ri,
                       input logic fv, input logic kg);
    io_w_valid      = wv;
    io_w_idx        = wi;
    io_w_ppn        = wp;
    io_w_flags      = wf;
    io_r_valid      = rv;
    io_r_idx        = ri;
    io_flush_valid  = fv;
    io_flush_keep_g = kg;
    #1;
  endtask

  task automatic idle_in();
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Advance one clock and score any read response that is due
  task automatic cycle();
    resp_t act;
    resp_t exp;
    @(posedge clock);
    #1;
    check("resp_valid", 64'(io_r_resp_valid), 64'(exp_q.size() != 0));
    if (io_r_resp_valid && exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      act = '{hit: io_r_hit, ppn: io_r_ppn, flags: io_r_flags, perr: io_r_perr};
      check("read_resp", 64'(act), 64'(exp));
    end
  endtask

  task automatic do_read(input logic [IDX_W-1:0] idx, input logic hit,
                         input logic [PPN_W-1:0] ppn, input logic [FLAG_W-1:0] flags,
                         input logic perr);
    drive(1'b0, '0, '0, '0, 1'b1, idx, 1'b0, 1'b0);
    exp_q.push_back('{hit: hit, ppn: ppn, flags: flags, perr: perr});
    cycle();
  endtask

  task automatic do_write(input logic [IDX_W-1:0] idx, input logic [PPN_W-1:0] ppn,
                          input logic [FLAG_W-1:0] flags);
    drive(1'b1, idx, ppn, flags, 1'b0, '0, 1'b0, 1'b0);
    check("w_ready_idle", 64'(io_w_ready), 64'(1));
    cycle();
  endtask

  // Flush with an optional competing write; checks busy length and ready gating
  task automatic do_flush(input logic keep, input logic wv, input logic [IDX_W-1:0] wi,
                          input logic [PPN_W-1:0] wp, input logic [FLAG_W-1:0] wf);
    drive(wv, wi, wp, wf, 1'b0, '0, 1'b1, keep);
    check("w_ready_flush_req", 64'(io_w_ready), 64'(0));
    cycle();
    idle_in();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      check("flush_busy", 64'(io_flush_busy), 64'(1));
      check("w_ready_busy", 64'(io_w_ready), 64'(0));
      cycle();
    end
    check("flush_done", 64'(io_flush_busy), 64'(0));
    check("w_ready_after", 64'(io_w_ready), 64'(1));
  endtask

  function automatic logic [PPN_W-1:0] fill_ppn(input int i);
    return PPN_W'(i * 32'h11111 + 1);
  endfunction

  function automatic logic [FLAG_W-1:0] fill_flags(input int i);
    logic [FLAG_W-1:0] f;
    f = FLAG_W'(i);
    if (i == 0 || i == 4) f[GBIT] = 1'b1;
    return f;
  endfunction

`ifdef TLB_ENTRY_PARITY_EN
  logic flip_bit;
`endif

  initial begin
    // w_v idx ppn flags r_v r_idx exp_hit exp_ppn exp_flags
    vecs[0] = '{1'b0, 3'd0, 20'h0,     14'h0,    1'b1, 3'd3, 1'b0, 20'h0,     14'h0};
    vecs[1] = '{1'b1, 3'd5, 20'hABCDE, 14'h3FFF, 1'b0, 3'd0, 1'b0, 20'h0,     14'h0};
    vecs[2] = '{1'b0, 3'd0, 20'h0,     14'h0,    1'b1, 3'd5, 1'b1, 20'hABCDE, 14'h3FFF};
    vecs[3] = '{1'b1, 3'd2, 20'h12345, 14'h0A5A, 1'b1, 3'd2, 1'b1, 20'h12345, 14'h0A5A};
    vecs[4] = '{1'b0, 3'd0, 20'h0,     14'h0,    1'b1, 3'd2, 1'b1, 20'h12345, 14'h0A5A};
    vecs[5] = '{1'b1, 3'd5, 20'hFFFFF, 14'h0001, 1'b1, 3'd7, 1'b0, 20'h0,     14'h0};
    vecs[6] = '{1'b0, 3'd0, 20'h0,     14'h0,    1'b1, 3'd5, 1'b1, 20'hFFFFF, 14'h0001};
    vecs[7] = '{1'b1, 3'd0, 20'h0,     14'h0,    1'b1, 3'd5, 1'b1, 20'hFFFFF, 14'h0001};
    vecs[8] = '{1'b0, 3'd0, 20'h0,     14'h0,    1'b1, 3'd0, 1'b1, 20'h0,     14'h0};

    reset = 1'b1;
    idle_in();
    cycle();
    cycle();
    check("rst_busy",   64'(io_flush_busy), 64'(0));
    check("rst_hit",    64'(io_r_hit), 64'(0));
    check("rst_ppn",    64'(io_r_ppn), 64'(0));
    check("rst_flags",  64'(io_r_flags), 64'(0));
    check("rst_perr",   64'(io_r_perr), 64'(0));
    check("rst_wready", 64'(io_w_ready), 64'(0));
    reset = 1'b0;
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].w_valid, vecs[i].w_idx, vecs[i].w_ppn, vecs[i].w_flags,
            vecs[i].r_valid, vecs[i].r_idx, 1'b0, 1'b0);
      check("w_ready_vec", 64'(io_w_ready), 64'(1));
      if (vecs[i].r_valid)
        exp_q.push_back('{hit: vecs[i].exp_hit, ppn: vecs[i].exp_ppn,
                          flags: vecs[i].exp_flags, perr: 1'b0});
      cycle();
    end

    // Response outputs hold while no read is issued
    idle_in();
    cycle();
    check("hold_hit", 64'(io_r_hit), 64'(1));
    check("hold_ppn", 64'(io_r_ppn), 64'(0));

    // Fill every entry; entries 0 and 4 are global
    for (int i = 0; i < int'(ENTRIES); i++) do_write(IDX_W'(i), fill_ppn(i), fill_flags(i));
    for (int i = 0; i < int'(ENTRIES); i++) do_read(IDX_W'(i), 1'b1, fill_ppn(i), fill_flags(i), 1'b0);

`ifdef TLB_ENTRY_PARITY_EN
    flip_bit = ~dut.par_q[1];
    force dut.par_q[1] = flip_bit;
    do_read(3'd1, 1'b1, fill_ppn(1), fill_flags(1), 1'b1);
    release dut.par_q[1];
    do_write(3'd1, fill_ppn(1), fill_flags(1));
`endif

    // Flush preserving globals: only 0 and 4 survive
    do_flush(1'b1, 1'b0, '0, '0, '0);
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (i == 0 || i == 4) do_read(IDX_W'(i), 1'b1, fill_ppn(i), fill_flags(i), 1'b0);
      else                  do_read(IDX_W'(i), 1'b0, '0, '0, 1'b0);
    end

    // Write colliding with flush request is dropped
    do_flush(1'b1, 1'b1, 3'd2, 20'h55555, 14'h1000);
    do_read(3'd2, 1'b0, '0, '0, 1'b0);
    do_read(3'd0, 1'b1, fill_ppn(0), fill_flags(0), 1'b0);

    // Full flush clears globals too
    do_flush(1'b0, 1'b0, '0, '0, '0);
    do_read(3'd0, 1'b0, '0, '0, 1'b0);
    do_read(3'd4, 1'b0, '0, '0, 1'b0);

    // Reset in the middle of a keep-global flush
    do_write(3'd6, 20'h0BEEF, 14'h1000);
    do_write(3'd1, 20'h0CAFE, 14'h1000);
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    cycle();
    idle_in();
    cycle();
    cycle();
    check("mid_busy", 64'(io_flush_busy), 64'(1));
    reset = 1'b1;
    #1;
    check("mid_rst_wready", 64'(io_w_ready), 64'(0));
    cycle();
    check("mid_rst_busy", 64'(io_flush_busy), 64'(0));
    reset = 1'b0;
    #1;
    check("post_rst_wready", 64'(io_w_ready), 64'(1));
    do_read(3'd6, 1'b0, '0, '0, 1'b0);
    do_read(3'd1, 1'b0, '0, '0, 1'b0);
    idle_in();
    cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
